ext_mem_slave_2ch: RTL and testbench

- Synthesizable dual-channel external-memory slave.
- Sits directly downstream of the HLS accelerator top's master memory port. It consumes the Mout_* request buses and produces the M_Rdata_ram / M_DataRdy response buses.
- Models fixed read/write latency over a byte-addressed window.
- Lets the accelerator run on hardware or in lint-clean simulation without a behavioural bench memory.

---
 rtl/ext_mem_pkg.sv | 27 ++
 rtl/ext_mem_chan_ctrl.sv | 92 +++++++++
 rtl/ext_mem_slave_2ch.sv | 115 +++++++++++
 tb/tb_ext_mem_slave_2ch.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// rtl/ext_mem_pkg.sv - shared defaults, request struct and byte-mask helper for ext_mem_slave_2ch
// Contents: default widths/latencies, chan_req_t, mask_bit()
package ext_mem_pkg;

  localparam int ADDR_W_DEF      = 7;
  localparam int DATA_W_DEF      = 8;
  localparam int SIZE_W_DEF      = 4;
  localparam int MEMSIZE_DEF     = 32;
  localparam int BASE_ADDR_DEF   = 0;
  localparam int READ_DELAY_DEF  = 2;
  localparam int WRITE_DELAY_DEF = 1;

  typedef struct packed {
    logic                  oe;
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [SIZE_W_DEF-1:0] size;
  } chan_req_t;

  // Bit bit_idx of the write mask (1<<size)-1; sizes at or above the data
  // width naturally give all ones, size 0 gives no bits.
  function automatic logic mask_bit(input int size, input int bit_idx);
    return bit_idx < size;
  endfunction

endpackage

// File: rtl/ext_mem_chan_ctrl.sv
// rtl/ext_mem_chan_ctrl.sv - per-channel window decode, write merge, ready counter, read pipe, conflict flag
// Ports: i_clk/i_rst (async active-high), i_oe/i_we/i_addr/i_wdata/i_size request,
//        i_mem_rdata = mem[o_idx]; o_idx/o_wr_en/o_wr_data write request to the array,
//        o_rdata read pipe output, o_rdy completion, o_err sticky conflict,
//        o_rd_done/o_wr_done in-window completions for the optional access counters.
module ext_mem_chan_ctrl
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SIZE_W      = SIZE_W_DEF,
  parameter int MEMSIZE     = MEMSIZE_DEF,
  parameter int BASE_ADDR   = BASE_ADDR_DEF,
  parameter int READ_DELAY  = READ_DELAY_DEF,
  parameter int WRITE_DELAY = WRITE_DELAY_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_oe,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [SIZE_W-1:0] i_size,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [31:0]       o_idx,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdy,
  output logic              o_err,
  output logic              o_rd_done,
  output logic              o_wr_done
);

  localparam int          NSTG    = READ_DELAY - 1;
  localparam logic [31:0] BASE    = 32'(BASE_ADDR);
  localparam logic [31:0] SPAN    = 32'(MEMSIZE);
  localparam logic [31:0] RD_LAST = 32'(READ_DELAY - 1);
  localparam logic [31:0] WR_LAST = 32'(WRITE_DELAY - 1);

  logic              w_hit;
  logic              w_rd_last;
  logic              w_wr_last;
  logic [DATA_W-1:0] w_mask;
  logic [31:0]       r_cnt;
  logic              r_err;
  logic [DATA_W-1:0] r_pipe [NSTG];

  // Addresses below the base wrap to huge offsets, so one compare covers both bounds.
  assign o_idx = 32'(i_addr) - BASE;
  assign w_hit = o_idx < SPAN;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < DATA_W; b++) w_mask[b] = mask_bit(int'(i_size), b);
  end

  assign o_wr_en   = w_hit & i_we & ~i_oe;
  assign o_wr_data = (i_wdata & w_mask) | (i_mem_rdata & ~w_mask);

  assign w_rd_last = (r_cnt == RD_LAST);
  assign w_wr_last = (r_cnt == WR_LAST);
  assign o_rdy     = w_hit & (w_rd_last | (i_we & w_wr_last));
  assign o_rd_done = w_hit & i_oe & ~i_we & w_rd_last;
  assign o_wr_done = w_hit & i_we & ~i_oe & w_wr_last;
  assign o_rdata   = r_pipe[0];
  assign o_err     = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
      for (int k = 0; k < NSTG; k++) r_pipe[k] <= '0;
    end else begin
      // Stage 0 is the output; data enters at the top so a same-cycle write is not seen.
      for (int k = 0; k < NSTG - 1; k++) r_pipe[k] <= r_pipe[k+1];
      r_pipe[NSTG-1] <= w_hit ? i_mem_rdata : '0;

      if (i_oe && i_we) begin
        r_err <= 1'b1;
        r_cnt <= '0;
      end else if (i_oe && w_hit) begin
        r_cnt <= (r_cnt < RD_LAST) ? r_cnt + 32'd1 : '0;
      end else if (i_we && w_hit) begin
        r_cnt <= (r_cnt < WR_LAST) ? r_cnt + 32'd1 : '0;
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ext_mem_slave_2ch.sv
// rtl/ext_mem_slave_2ch.sv - dual-channel fixed-latency external-memory slave (optional macro EXT_MEM_ACCESS_COUNT_EN)
// Ports: clock, reset (async active-high); Mout_* per-channel request buses (channel c at [c*W +: W]);
//        Sout_Rdata_ram/Sout_DataRdy ORed into M_Rdata_ram/M_DataRdy; err_conflict sticky oe&we flag;
//        rd_count/wr_count saturating completion counters when EXT_MEM_ACCESS_COUNT_EN is defined.
module ext_mem_slave_2ch
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SIZE_W      = SIZE_W_DEF,
  parameter int MEMSIZE     = MEMSIZE_DEF,
  parameter int BASE_ADDR   = BASE_ADDR_DEF,
  parameter int READ_DELAY  = READ_DELAY_DEF,
  parameter int WRITE_DELAY = WRITE_DELAY_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          Mout_oe_ram,
  input  logic [1:0]          Mout_we_ram,
  input  logic [2*ADDR_W-1:0] Mout_addr_ram,
  input  logic [2*DATA_W-1:0] Mout_Wdata_ram,
  input  logic [2*SIZE_W-1:0] Mout_data_ram_size,
  input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy,
  output logic [2*DATA_W-1:0] M_Rdata_ram,
  output logic [1:0]          M_DataRdy,
`ifdef EXT_MEM_ACCESS_COUNT_EN
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count,
`endif
  output logic [1:0]          err_conflict
);

  logic [DATA_W-1:0] r_mem [MEMSIZE];
  logic [1:0]        w_rdy;
  logic [1:0]        w_rd_done;
  logic [1:0]        w_wr_done;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [31:0]       w_idx;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_mem_rd;
    logic [DATA_W-1:0] w_rdata;

    always_comb begin
      w_mem_rd = '0;
      for (int i = 0; i < MEMSIZE; i++) if (w_idx == 32'(i)) w_mem_rd = r_mem[i];
    end

    ext_mem_chan_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .MEMSIZE(MEMSIZE),
      .BASE_ADDR(BASE_ADDR), .READ_DELAY(READ_DELAY), .WRITE_DELAY(WRITE_DELAY)
    ) u_ctrl (
      .i_clk      (clock),
      .i_rst      (reset),
      .i_oe       (Mout_oe_ram[g]),
      .i_we       (Mout_we_ram[g]),
      .i_addr     (Mout_addr_ram[g*ADDR_W +: ADDR_W]),
      .i_wdata    (Mout_Wdata_ram[g*DATA_W +: DATA_W]),
      .i_size     (Mout_data_ram_size[g*SIZE_W +: SIZE_W]),
      .i_mem_rdata(w_mem_rd),
      .o_idx      (w_idx),
      .o_wr_en    (w_wr_en),
      .o_wr_data  (w_wr_data),
      .o_rdata    (w_rdata),
      .o_rdy      (w_rdy[g]),
      .o_err      (err_conflict[g]),
      .o_rd_done  (w_rd_done[g]),
      .o_wr_done  (w_wr_done[g])
    );

    assign M_Rdata_ram[g*DATA_W +: DATA_W] = w_rdata | Sout_Rdata_ram[g*DATA_W +: DATA_W];
  end

  assign M_DataRdy = Sout_DataRdy | w_rdy;

  // Channel 1 is applied after channel 0, so it wins a same-byte collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEMSIZE; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < MEMSIZE; i++) begin
        if (g_ch[0].w_wr_en && g_ch[0].w_idx == 32'(i)) r_mem[i] <= g_ch[0].w_wr_data;
        if (g_ch[1].w_wr_en && g_ch[1].w_idx == 32'(i)) r_mem[i] <= g_ch[1].w_wr_data;
      end
    end
  end

`ifdef EXT_MEM_ACCESS_COUNT_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic [31:0] w_rd_inc;
  logic [31:0] w_wr_inc;

  assign w_rd_inc = 32'(w_rd_done[0]) + 32'(w_rd_done[1]);
  assign w_wr_inc = 32'(w_wr_done[0]) + 32'(w_wr_done[1]);
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_rd_count <= (r_rd_count > 32'hFFFF_FFFF - w_rd_inc) ? 32'hFFFF_FFFF : r_rd_count + w_rd_inc;
      r_wr_count <= (r_wr_count > 32'hFFFF_FFFF - w_wr_inc) ? 32'hFFFF_FFFF : r_wr_count + w_wr_inc;
    end
  end
`else
  logic w_unused_done;
  assign w_unused_done = ^{w_rd_done, w_wr_done};
`endif

endmodule

// File: tb/tb_ext_mem_slave_2ch.sv
// tb/tb_ext_mem_slave_2ch.sv - directed self-checking bench for ext_mem_slave_2ch
module tb_ext_mem_slave_2ch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  oe = '0;
  logic [1:0]  we = '0;
  logic [13:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [7:0]  size = '0;
  logic [15:0] sout_rd = '0;
  logic [1:0]  sout_rdy = '0;
  logic [15:0] m_rdata;
  logic [1:0]  m_rdy;
  logic [1:0]  err;
`ifdef EXT_MEM_ACCESS_COUNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ext_mem_slave_2ch dut (
    .clock             (clock),
    .reset             (reset),
    .Mout_oe_ram       (oe),
    .Mout_we_ram       (we),
    .Mout_addr_ram     (addr),
    .Mout_Wdata_ram    (wdata),
    .Mout_data_ram_size(size),
    .Sout_Rdata_ram    (sout_rd),
    .Sout_DataRdy      (sout_rdy),
    .M_Rdata_ram       (m_rdata),
    .M_DataRdy         (m_rdy),
`ifdef EXT_MEM_ACCESS_COUNT_EN
    .rd_count          (rd_count),
    .wr_count          (wr_count),
`endif
    .err_conflict      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ch0(input logic o, input logic w, input logic [6:0] a, input logic [7:0] d, input logic [3:0] s);
    oe[0] = o; we[0] = w; addr[6:0] = a; wdata[7:0] = d; size[3:0] = s;
  endtask

  task automatic ch1(input logic o, input logic w, input logic [6:0] a, input logic [7:0] d, input logic [3:0] s);
    oe[1] = o; we[1] = w; addr[13:7] = a; wdata[15:8] = d; size[7:4] = s;
  endtask

  // Advance to just after the next rising edge; inputs are then changed and checked 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    #1;
    chk("rst_rdy", 32'(m_rdy), 32'h0);
    chk("rst_rdata", 32'(m_rdata), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    tick();
    reset = 1'b0;

    // Write A5 to addr 3, then 2-cycle read
    ch0(1'b0, 1'b1, 7'd3, 8'hA5, 4'd8); #1;
    chk("wr3_rdy", 32'(m_rdy[0]), 32'h1);
    tick(); ch0(1'b1, 1'b0, 7'd3, 8'h00, 4'd8); #1;
    chk("rd3_c1_rdy", 32'(m_rdy[0]), 32'h0);
    tick(); #1;
    chk("rd3_c2_rdy", 32'(m_rdy[0]), 32'h1);
    chk("rd3_c2_data", 32'(m_rdata[7:0]), 32'hA5);

    // Partial-size writes to addr 5 and a full-width oversize write to addr 6
    tick(); ch0(1'b0, 1'b1, 7'd5, 8'hFF, 4'd8);
    tick(); ch0(1'b0, 1'b1, 7'd5, 8'h00, 4'd4);
    tick(); ch0(1'b0, 1'b1, 7'd5, 8'hAA, 4'd0);
    tick(); ch0(1'b1, 1'b0, 7'd5, 8'h00, 4'd8);
    tick(); #1;
    chk("rd5_size4_data", 32'(m_rdata[7:0]), 32'hF0);
    tick(); ch0(1'b0, 1'b1, 7'd6, 8'h3C, 4'd12);
    tick(); ch0(1'b1, 1'b0, 7'd6, 8'h00, 4'd8);
    tick(); #1;
    chk("rd6_size12_data", 32'(m_rdata[7:0]), 32'h3C);

    // Both channels write addr 7: channel 1 wins
    tick(); ch0(1'b0, 1'b1, 7'd7, 8'h11, 4'd8); ch1(1'b0, 1'b1, 7'd7, 8'h22, 4'd8); #1;
    chk("dual_wr_rdy", 32'(m_rdy), 32'h3);
    tick(); ch1(1'b0, 1'b0, 7'd0, 8'h00, 4'd0); ch0(1'b1, 1'b0, 7'd7, 8'h00, 4'd8);
    tick(); #1;
    chk("dual_wr_data", 32'(m_rdata[7:0]), 32'h22);

    // Out-of-window read: only the Sout inputs reach the outputs
    tick(); ch0(1'b0, 1'b0, 7'd40, 8'h00, 4'd8); sout_rd = 16'h0033;
    tick(); ch0(1'b1, 1'b0, 7'd40, 8'h00, 4'd8); #1;
    chk("oow_c1_rdy", 32'(m_rdy[0]), 32'h0);
    chk("oow_c1_data", 32'(m_rdata[7:0]), 32'h33);
    tick(); #1;
    chk("oow_c2_rdy", 32'(m_rdy[0]), 32'h0);
    chk("oow_c2_data", 32'(m_rdata[7:0]), 32'h33);
    tick(); #1;
    chk("oow_c3_rdy", 32'(m_rdy[0]), 32'h0);
    sout_rdy = 2'b01; #1;
    chk("oow_sout_rdy", 32'(m_rdy[0]), 32'h1);
    sout_rdy = 2'b00; sout_rd = 16'h0000;

    // Conflict on channel 1 at addr 2
    tick(); ch0(1'b0, 1'b0, 7'd0, 8'h00, 4'd0); ch1(1'b0, 1'b1, 7'd2, 8'h5A, 4'd8);
    tick(); ch1(1'b1, 1'b1, 7'd2, 8'hC3, 4'd8); #1;
    chk("conf_pre_err", 32'(err), 32'h0);
    tick(); ch1(1'b0, 1'b0, 7'd2, 8'h00, 4'd8); #1;
    chk("conf_err_set", 32'(err), 32'h2);
    tick(); tick(); #1;
    chk("conf_err_sticky", 32'(err), 32'h2);
    ch1(1'b1, 1'b0, 7'd2, 8'h00, 4'd8);
    tick(); #1;
    chk("conf_mem_rdy", 32'(m_rdy[1]), 32'h1);
    chk("conf_mem_kept", 32'(m_rdata[15:8]), 32'h5A);
    tick(); ch1(1'b0, 1'b0, 7'd0, 8'h00, 4'd0);

    // Reset in the middle of a read of addr 4
    ch0(1'b0, 1'b1, 7'd4, 8'h77, 4'd8);
    tick(); ch0(1'b1, 1'b0, 7'd4, 8'h00, 4'd8);
    tick();
    reset = 1'b1; #1;
    chk("midrst_rdy", 32'(m_rdy[0]), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_rdata", 32'(m_rdata), 32'h0);
    tick();
    reset = 1'b0; #1;
    chk("reissue_c1_rdy", 32'(m_rdy[0]), 32'h0);
    tick(); #1;
    chk("reissue_c2_rdy", 32'(m_rdy[0]), 32'h1);
    chk("reissue_mem4", 32'(m_rdata[7:0]), 32'h00);
    chk("post_rst_err", 32'(err), 32'h0);
    tick(); ch0(1'b0, 1'b0, 7'd0, 8'h00, 4'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
